// File: rtl/micro_seq_pkg.sv
// Shared definitions for the microprogram sequencer: states, opcodes and
// microcode word field positions.
package micro_seq_pkg;

  localparam int unsigned CTRL_W = 12;
  localparam int unsigned WCNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT
  } state_e;

  localparam logic [3:0] OP_OUT    = 4'h0;
  localparam logic [3:0] OP_HALT   = 4'h1;
  localparam logic [3:0] OP_BRANCH = 4'h2;
  localparam logic [3:0] OP_WAIT   = 4'h4;
  localparam logic [3:0] OP_CALL   = 4'h8;
  localparam logic [3:0] OP_RET    = 4'hC;

  localparam int unsigned OP_HI   = 15;
  localparam int unsigned OP_LO   = 12;
  localparam int unsigned POL_BIT = 10;
  localparam int unsigned SEL_HI  = 9;
  localparam int unsigned SEL_LO  = 8;
  localparam int unsigned WCNT_HI = 7;
  localparam int unsigned WCNT_LO = 0;
  localparam int unsigned TGT_HI  = 5;
  localparam int unsigned TGT_LO  = 0;
  localparam int unsigned CTRL_HI = 11;
  localparam int unsigned CTRL_LO = 0;

endpackage

// File: rtl/micro_sequencer_if.sv
// Read port between the sequencer (master) and the registered-output microcode ROM (slave).
interface micro_sequencer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 20
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_en, output rom_addr, input rom_data);
  modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/micro_ret_stack.sv
// Return-address LIFO for CALL/RET; top is the most recently pushed entry.
module micro_ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);
  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0] sp;
  logic [W-1:0]    mem [DEPTH];

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);
  assign top   = empty ? '0 : mem[IDX_W'(sp - SP_W'(1))];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      mem[IDX_W'(sp)] <= din;
      sp              <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end
endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetches words from a registered ROM, emits control
// words, branches on condition flags, waits, and calls/returns via a small stack.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 20,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  input  logic [3:0]        cond_in,
  micro_sequencer_if.master rom,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic              ctrl_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, tgt, stk_top;
  logic [WCNT_W-1:0] wait_cnt, wcnt_n, wait_n;
  logic [CTRL_W-1:0] ctrl_n;
  logic              cv_n, done_n, err_n;
  logic              push, pop, clear, stk_full, stk_empty, taken;
  logic [3:0]        op;
  logic              unused_hi;

  // Upper word bits carry no meaning for this sequencer.
  assign unused_hi = ^rom.rom_data[DATA_W-1:OP_HI+1];

  assign op     = rom.rom_data[OP_HI:OP_LO];
  assign tgt    = rom.rom_data[TGT_HI:TGT_LO];
  assign wait_n = rom.rom_data[WCNT_HI:WCNT_LO];
  assign taken  = (cond_in[rom.rom_data[SEL_HI:SEL_LO]] == rom.rom_data[POL_BIT]);
  assign pc_inc = pc + ADDR_W'(1);

  micro_ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (pc_inc),
    .full  (stk_full),
    .empty (stk_empty),
    .top   (stk_top)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      wait_cnt   <= '0;
      ctrl_word  <= '0;
      ctrl_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      wait_cnt   <= wcnt_n;
      ctrl_word  <= ctrl_n;
      ctrl_valid <= cv_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    wcnt_n  = wait_cnt;
    ctrl_n  = ctrl_word;
    cv_n    = 1'b0;
    done_n  = 1'b0;
    err_n   = err;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
      clear   = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          pc_n    = start_addr;
          err_n   = 1'b0;
          clear   = 1'b1;
          state_n = S_FETCH;
        end
        S_FETCH: state_n = S_EXEC;
        S_EXEC: begin
          case (op)
            OP_OUT: begin
              ctrl_n  = rom.rom_data[CTRL_HI:CTRL_LO];
              cv_n    = 1'b1;
              pc_n    = pc_inc;
              state_n = S_FETCH;
            end
            OP_HALT: begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end
            OP_BRANCH: begin
              pc_n    = taken ? tgt : pc_inc;
              state_n = S_FETCH;
            end
            OP_WAIT: begin
              if (wait_n == '0) begin
                pc_n    = pc_inc;
                state_n = S_FETCH;
              end else begin
                wcnt_n  = wait_n;
                state_n = S_WAIT;
              end
            end
            OP_CALL: begin
              if (stk_full) begin
                err_n   = 1'b1;
                state_n = S_IDLE;
              end else begin
                push    = 1'b1;
                pc_n    = tgt;
                state_n = S_FETCH;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                err_n   = 1'b1;
                state_n = S_IDLE;
              end else begin
                pop     = 1'b1;
                pc_n    = stk_top;
                state_n = S_FETCH;
              end
            end
            default: begin
              err_n   = 1'b1;
              state_n = S_IDLE;
            end
          endcase
        end
        S_WAIT: begin
          wcnt_n = wait_cnt - WCNT_W'(1);
          if (wait_cnt == WCNT_W'(1)) begin
            pc_n    = pc_inc;
            state_n = S_FETCH;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // An abort arriving during FETCH suppresses the read in that same cycle.
  always_comb begin
    rom.rom_en = (state == S_FETCH) && !abort;
    busy       = (state != S_IDLE);
  end

  assign rom.rom_addr = pc;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer directly upstream of the 64x20 registered-output microcode ROM.
- Drives the ROM enable and 6-bit address, and consumes the 20-bit word one cycle later.
- Decodes each word to emit control words, branch on condition inputs, wait, and call/return.
- Sits between the host control logic (start/abort) and the ROM.

Parameters:
- ADDR_W, 6, ROM address width.
- DATA_W, 20, ROM word width.
- STACK_DEPTH, 4, return-address stack entries (1..8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run from start_addr; honoured only in IDLE.
- start_addr  in  6  entry point of the microprogram.
- abort  in  1  forces return to IDLE.
- cond_in  in  4  branch condition flags, sampled in EXEC.
- rom_en  out  1  ROM read enable.
- rom_addr  out  6  ROM address (equal to the pc register).
- rom_data  in  20  ROM registered output; valid the cycle after rom_en=1.
- ctrl_word  out  12  last emitted control word (held).
- ctrl_valid  out  1  one-cycle pulse when ctrl_word updates.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on HALT.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset values: state=IDLE, pc=0, sp=0, wait_cnt=0, ctrl_word=0, rom_en=0, ctrl_valid=0, busy=0, done=0, err=0.
- States and transitions:
  - IDLE: on start, pc<=start_addr, err<=0, go to FETCH.
  - FETCH: rom_en=1 and rom_addr=pc for exactly one cycle; always go to EXEC.
  - EXEC: rom_data is valid; decode op=rom_data[15:12]. rom_data[19:16] is ignored.
  - WAIT: wait_cnt decrements each cycle; when it reaches 1, pc<=pc+1 and go to FETCH.
- Opcodes, decoded in EXEC:
  - 0x0 OUT: ctrl_word<=rom_data[11:0]; ctrl_valid=1 on the next cycle; pc<=pc+1; go to FETCH.
  - 0x1 HALT: done=1 on the next cycle; go to IDLE.
  - 0x2 BRANCH: taken when cond_in[rom_data[9:8]] equals rom_data[10]. Taken: pc<=rom_data[5:0]; not taken: pc<=pc+1. Go to FETCH.
  - 0x4 WAIT: n=rom_data[7:0]. If n=0, behaves as NOP (pc+1, go to FETCH). Otherwise wait_cnt<=n and go to WAIT, giving exactly n extra cycles.
  - 0x8 CALL: push pc+1 (mod 64); pc<=rom_data[5:0]. If the stack is full: err<=1, go to IDLE, no done pulse.
  - 0xC RET: pop into pc. If the stack is empty: err<=1, go to IDLE, no done pulse.
  - Any other opcode: err<=1, go to IDLE, no done pulse.
- Timing: minimum 2 cycles per instruction (FETCH+EXEC); WAIT n costs 2+n cycles.
- ROM read rules: rom_en is low outside FETCH, so the ROM output holds through EXEC and WAIT. No read is issued in IDLE.
- pc arithmetic: pc+1 wraps modulo 64 (63 -> 0); no error on wrap.
- Stack: sp resets to 0 on every accepted start.
- abort: has priority over everything, in any state. Go to IDLE next cycle, rom_en=0, no done, no ctrl_valid, err unchanged, stack cleared.
- Other boundary conditions:
  - start while busy is ignored.
  - start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- Async rst: returns all state to reset values at any point, mid-WAIT or mid-CALL included.

Decomposition:
- Package micro_seq_pkg holds:
  - opcode constants OP_OUT, OP_HALT, OP_BRANCH, OP_WAIT, OP_CALL, OP_RET;
  - state encodings;
  - field positions (op 15:12, target 5:0, cond sel 9:8, polarity 10, wait count 7:0, control 11:0).
- One sub-module, micro_ret_stack: STACK_DEPTH x 6 LIFO with push, pop, clear, full, empty, top.

Test Plan:
- OUT sequence: ROM[5]=0x00ABC, ROM[6]=0x01000; start_addr=5 -> rom_addr 5 then 6. ctrl_word=0xABC with ctrl_valid 3 cycles after start. done pulse 5 cycles after start; busy low afterwards.
- Branch: ROM[0]=0x02528 (sel 1, pol 1, target 0x28), cond_in=4'b0010 -> next fetch at 0x28. With cond_in=0, next fetch at 1.
- Wait/wrap: ROM[63]=0x04003, ROM[0]=0x01000 -> 3 idle cycles with rom_en=0, then fetch at address 0, then done.
- Call/return and overflow: CALL at 10 to 20, RET at 20 -> next fetch 11. Nested CALLs to depth 5 with STACK_DEPTH=4 -> err=1, IDLE, no done.
- Errors and abort: RET with an empty stack -> err=1. Opcode 0x3 -> err=1. abort during WAIT n=200 -> IDLE next cycle, no done.
- Reset and start rules: rst asserted mid-CALL -> all outputs at reset values immediately. start while busy is ignored.
